// File: rtl/pulse_train_pkg.sv
// Shared types and elaboration helpers for the pulse train transmitter.
package pulse_train_pkg;

   // Transmitter sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Both phases must last at least one whole cycle, otherwise edges could merge.
   function automatic bit phase_params_ok(int high_cycles, int low_cycles);
      return (high_cycles >= 1) && (low_cycles >= 1);
   endfunction

   // Width of a down-counter that must hold max(high, low) - 1 (and never less than 1 bit).
   function automatic int timer_width(int high_cycles, int low_cycles);
      int m;
      m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
      if (m < 1) m = 1;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pulse_train_tx_if.sv
// Command channel into the pulse train transmitter.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. The master holds cmd_valid (with cmd_count) until
// that edge; cmd_count is only sampled at the transfer edge and may change
// freely afterwards. cmd_ready never depends combinationally on cmd_valid.
interface pulse_train_tx_if #(
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_count;

   modport master (output cmd_valid, output cmd_count, input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_count, output cmd_ready);
endinterface

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; zero marks the last cycle.
module pulse_phase_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Load on phase entry, otherwise count down and park at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_train_tx.sv
// Emits exactly cmd_count clean, clock-aligned rising edges on pulse_out per command.
module pulse_train_tx
   import pulse_train_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int HIGH_CYCLES = 1,
   parameter int LOW_CYCLES  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   pulse_train_tx_if.slave        cmd,
   output logic                   pulse_out,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       edges_sent,
   output state_t                 state_dbg
);

   if (!phase_params_ok(HIGH_CYCLES, LOW_CYCLES)) begin : g_param_err
      $error("pulse_train_tx: HIGH_CYCLES and LOW_CYCLES must both be >= 1");
   end

   localparam int           TW     = timer_width(HIGH_CYCLES, LOW_CYCLES);
   localparam logic [TW-1:0] H_LOAD = TW'(HIGH_CYCLES - 1);
   localparam logic [TW-1:0] L_LOAD = TW'(LOW_CYCLES - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] edges_q;
   logic             pulse_q;
   logic             timer_load;
   logic [TW-1:0]    timer_val;
   logic             timer_zero;

   pulse_phase_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and timer reload decisions.
   always_comb begin
      state_nx   = state;
      timer_load = 1'b0;
      timer_val  = H_LOAD;
      case (state)
         IDLE: begin
            if (cmd.cmd_valid) begin
               timer_load = 1'b1;
               timer_val  = H_LOAD;
               state_nx   = (cmd.cmd_count == '0) ? DONE : HIGH;
            end
         end
         HIGH: begin
            if (timer_zero) begin
               timer_load = 1'b1;
               timer_val  = L_LOAD;
               state_nx   = LOW;
            end
         end
         LOW: begin
            if (timer_zero) begin
               if (remaining == '0) begin
                  state_nx = DONE;
               end else begin
                  timer_load = 1'b1;
                  timer_val  = H_LOAD;
                  state_nx   = HIGH;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Pulse count bookkeeping and the registered pulse line (high exactly while in HIGH).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= '0;
         edges_q   <= '0;
         pulse_q   <= 1'b0;
      end else begin
         pulse_q <= (state_nx == HIGH);
         case (state)
            IDLE: begin
               if (cmd.cmd_valid) begin
                  remaining <= cmd.cmd_count;
                  // Clear, then count the first edge that follows immediately.
                  edges_q   <= (cmd.cmd_count == '0) ? '0 : CNT_W'(1);
               end
            end
            HIGH: begin
               if (timer_zero) remaining <= remaining - 1'b1;
            end
            LOW: begin
               if (timer_zero && (remaining != '0)) edges_q <= edges_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cmd.cmd_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);
   assign pulse_out     = pulse_q;
   assign edges_sent    = edges_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_pulse_train_tx.sv
// Bench for pulse_train_tx: a default-timing instance (a) and a 3/2 timing instance (b).
module tb_pulse_train_tx;
   import pulse_train_pkg::*;

   localparam int CNT_W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   pulse_train_tx_if #(.CNT_W(CNT_W)) if_a ();
   pulse_train_tx_if #(.CNT_W(CNT_W)) if_b ();

   logic             pulse_a, busy_a, done_a;
   logic             pulse_b, busy_b, done_b;
   logic [CNT_W-1:0] edges_a, edges_b;
   state_t           st_a, st_b;

   pulse_train_tx #(.CNT_W(CNT_W), .HIGH_CYCLES(1), .LOW_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .cmd(if_a.slave), .pulse_out(pulse_a), .busy(busy_a),
      .done(done_a), .edges_sent(edges_a), .state_dbg(st_a));

   pulse_train_tx #(.CNT_W(CNT_W), .HIGH_CYCLES(3), .LOW_CYCLES(2)) dut_b (
      .clk(clk), .rst(rst), .cmd(if_b.slave), .pulse_out(pulse_b), .busy(busy_b),
      .done(done_b), .edges_sent(edges_b), .state_dbg(st_b));

   // Independent edge consumers and done counters.
   int pos_a = 0, pos_b = 0, done_cnt_a = 0;
   always @(posedge pulse_a) pos_a++;
   always @(posedge pulse_b) pos_b++;
   always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [0:0] exp_q[$];
   logic       pulse_log[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic get_ready(int s); return (s == 0) ? if_a.cmd_ready : if_b.cmd_ready; endfunction
   function automatic logic get_done (int s); return (s == 0) ? done_a  : done_b;  endfunction
   function automatic logic get_pulse(int s); return (s == 0) ? pulse_a : pulse_b; endfunction
   function automatic logic get_busy (int s); return (s == 0) ? busy_a  : busy_b;  endfunction
   function automatic logic [CNT_W-1:0] get_edges(int s); return (s == 0) ? edges_a : edges_b; endfunction
   function automatic logic get_valid(int s); return (s == 0) ? if_a.cmd_valid : if_b.cmd_valid; endfunction
   function automatic int   get_count(int s); return (s == 0) ? int'(if_a.cmd_count) : int'(if_b.cmd_count); endfunction

   // ---------------- behavioural model + compare ----------------
   // Model: after accepting N, cycle k (k=1..N*P) lies in pulse (k-1)/P, high when
   // (k-1)%P < H; cycle N*P+1 is the done cycle; then idle.
   int m_h[2] = '{1, 3};
   int m_l[2] = '{1, 2};
   bit m_run[2];
   int m_k[2], m_n[2], m_edges[2];

   // Compare every output of both DUTs each cycle, then advance the model.
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         int p, total, j;
         logic ep, eb, ed, er;
         int ee;
         if (rst) begin
            m_run[s] = 1'b0; m_k[s] = 0; m_n[s] = 0; m_edges[s] = 0;
         end
         p = m_h[s] + m_l[s];
         total = m_n[s] * p;
         if (!m_run[s]) begin
            ep = 0; eb = 0; ed = 0; er = 1; ee = m_edges[s];
         end else if (m_k[s] <= total) begin
            j = m_k[s] - 1;
            ep = ((j % p) < m_h[s]); eb = 1; ed = 0; er = 0; ee = j / p + 1;
         end else begin
            ep = 0; eb = 1; ed = 1; er = 0; ee = m_n[s];
         end
         check($sformatf("model_pulse%0d", s), 32'(get_pulse(s)), 32'(ep));
         check($sformatf("model_busy%0d", s),  32'(get_busy(s)),  32'(eb));
         check($sformatf("model_done%0d", s),  32'(get_done(s)),  32'(ed));
         check($sformatf("model_ready%0d", s), 32'(get_ready(s)), 32'(er));
         check($sformatf("model_edges%0d", s), 32'(get_edges(s)), 32'(ee));
         if (!rst) begin
            if (m_run[s]) begin
               if (m_k[s] == total + 1) begin
                  m_run[s] = 1'b0; m_edges[s] = m_n[s];
               end else begin
                  m_k[s]++;
               end
            end else if (get_valid(s) === 1'b1) begin
               m_run[s] = 1'b1; m_k[s] = 1; m_n[s] = get_count(s);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_in(input int s, input logic v, input int c);
      if (s == 0) begin if_a.cmd_valid = v; if_a.cmd_count = CNT_W'(c); end
      else        begin if_b.cmd_valid = v; if_b.cmd_count = CNT_W'(c); end
   endtask

   // Present a command, hold until accepted; acc = cycle index of the accepting cycle.
   task automatic send(input int s, input int c, output int acc);
      set_in(s, 1'b1, c);
      acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (get_ready(s) === 1'b1) begin acc = cyc; break; end
      end
      check("accept_seen", 32'(acc >= 0), 32'd1);
      @(posedge clk); #1;
      set_in(s, 1'b0, 0);
   endtask

   // Wait for done; k = cycles from accepting cycle to done, pulse_log holds pulse per cycle.
   task automatic wait_done(input int s, input int acc, output int k);
      k = -1;
      pulse_log.delete();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         pulse_log.push_back(get_pulse(s));
         if (get_done(s) === 1'b1) begin k = cyc - acc; break; end
      end
      check("done_seen", 32'(k >= 0), 32'd1);
      @(posedge clk); #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int acc, acc2, k, snap, done_c, dsnap;
      logic [10:0] pat_b;

      rst = 1'b1;
      set_in(0, 1'b0, 0);
      set_in(1, 1'b0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_pulse", 32'(pulse_a), 32'd0);
      check("rst_ready", 32'(if_a.cmd_ready), 32'd1);
      check("rst_busy",  32'(busy_a), 32'd0);
      check("rst_done",  32'(done_a), 32'd0);
      check("rst_edges", 32'(edges_a), 32'd0);
      check("rst_state", 32'(st_a == IDLE), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Default timing, count 4: 1,0,1,0,1,0,1,0 then done on cycle 9.
      snap = pos_a;
      send(0, 4, acc);
      wait_done(0, acc, k);
      check("t1_done_cycle", 32'(k), 32'd9);
      check("t1_edges", 32'(edges_a), 32'd4);
      check("t1_posedges", 32'(pos_a - snap), 32'd4);
      for (int i = 0; i < 4; i++) begin exp_q.push_back(1'b1); exp_q.push_back(1'b0); end
      check("t1_log_len", 32'(pulse_log.size()), 32'd9);
      for (int i = 0; i < 8; i++) begin
         logic [0:0] e;
         e = exp_q.pop_front();
         if (i < pulse_log.size()) check($sformatf("t1_pulse_k%0d", i + 1), 32'(pulse_log[i]), 32'(e));
      end

      // 3/2 timing, count 2: high 3 / low 2 / high 3 / low 2, done at cycle 11.
      snap = pos_b;
      send(1, 2, acc);
      wait_done(1, acc, k);
      check("t2_done_cycle", 32'(k), 32'd11);
      check("t2_posedges", 32'(pos_b - snap), 32'd2);
      check("t2_edges", 32'(edges_b), 32'd2);
      pat_b = 11'b11100111000;
      check("t2_log_len", 32'(pulse_log.size()), 32'd11);
      for (int i = 0; i < 11; i++)
         if (i < pulse_log.size()) check($sformatf("t2_pulse_k%0d", i + 1), 32'(pulse_log[i]), 32'(pat_b[10 - i]));

      // Count 0: no pulse, done one cycle after accept.
      snap = pos_a;
      send(0, 0, acc);
      wait_done(0, acc, k);
      check("t3_done_cycle", 32'(k), 32'd1);
      check("t3_edges", 32'(edges_a), 32'd0);
      check("t3_posedges", 32'(pos_a - snap), 32'd0);
      check("t3_ready_after", 32'(if_a.cmd_ready), 32'd1);

      // Reset in the middle of a high phase of a count-5 train.
      dsnap = done_cnt_a;
      send(0, 5, acc);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t4_pre_rst_pulse", 32'(pulse_a), 32'd1);
      rst = 1'b1;
      #1;
      check("t4_rst_pulse", 32'(pulse_a), 32'd0);
      check("t4_rst_busy",  32'(busy_a), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t4_no_done", 32'(done_cnt_a - dsnap), 32'd0);
      check("t4_ready", 32'(if_a.cmd_ready), 32'd1);
      snap = pos_a;
      send(0, 1, acc);
      wait_done(0, acc, k);
      check("t4_done_cycle", 32'(k), 32'd3);
      check("t4_posedges", 32'(pos_a - snap), 32'd1);
      check("t4_edges", 32'(edges_a), 32'd1);

      // cmd_valid held with a changing count during a train of 3.
      snap = pos_a;
      set_in(0, 1'b1, 3);
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (if_a.cmd_ready === 1'b1) begin acc = cyc; break; end
      end
      check("t5_accept1", 32'(acc >= 0), 32'd1);
      done_c = -1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if_a.cmd_count = CNT_W'($urandom_range(1, 9));
         @(negedge clk);
         if (done_a === 1'b1) begin done_c = cyc; break; end
      end
      check("t5_done_cycle", 32'(done_c - acc), 32'd7);
      check("t5_edges", 32'(edges_a), 32'd3);
      check("t5_posedges", 32'(pos_a - snap), 32'd3);
      @(posedge clk); #1;
      if_a.cmd_count = CNT_W'(2);
      @(negedge clk);
      acc2 = (if_a.cmd_ready === 1'b1) ? cyc : -1;
      check("t5_accept2_gap", 32'(acc2 - done_c), 32'd1);
      @(posedge clk); #1;
      set_in(0, 1'b0, 0);
      wait_done(0, acc2, k);
      check("t5_second_done", 32'(k), 32'd5);
      check("t5_second_edges", 32'(edges_a), 32'd2);

      // Maximum count: 255 edges, no wrap, one done.
      snap  = pos_a;
      dsnap = done_cnt_a;
      send(0, 255, acc);
      wait_done(0, acc, k);
      check("t6_done_cycle", 32'(k), 32'd511);
      check("t6_edges", 32'(edges_a), 32'd255);
      check("t6_posedges", 32'(pos_a - snap), 32'd255);
      repeat (4) @(posedge clk);
      #1;
      check("t6_done_once", 32'(done_cnt_a - dsnap), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_train_tx.md
Name: pulse_train_tx

Overview:
- Transmitter side of the edge-event link between blocks.
- On a handshaked command it emits exactly N clean rising edges on `pulse_out`.
- Every high phase and every low phase is a registered, clock-aligned level lasting whole cycles. A synchronous edge receiver in another block therefore sees every edge, with no same-timestep glitch or ordering race.
- Sits between a command-issuing controller and any `posedge`/edge-sampling consumer.

Parameters:
- CNT_W, 8, width of the pulse count and of `edges_sent`.
- HIGH_CYCLES, 1, cycles `pulse_out` stays high per pulse; must be at least 1.
- LOW_CYCLES, 1, cycles `pulse_out` stays low after each pulse; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (state IDLE).
- cmd_count  in  CNT_W  number of pulses to emit; sampled at acceptance.
- pulse_out  out  1  generated pulse line (registered).
- busy  out  1  command in progress (state is not IDLE).
- done  out  1  one-cycle completion strobe.
- edges_sent  out  CNT_W  rising edges emitted for the current or last command.

Behaviour:
- Reset values (apply immediately on `rst`, independent of clk): pulse_out=0, busy=0, done=0, edges_sent=0, state=IDLE, cmd_ready=1.
- Reset mid-train: the line drops low at once, no `done` strobe, and the command is discarded.
- Every output is a register or a pure decode of the state register. No combinational path from `cmd_valid` to any output.
- States:
  - IDLE: cmd_ready=1. On `cmd_valid` (handshake `cmd_valid & cmd_ready`), latch `cmd_count` into `remaining` and clear `edges_sent`.
    - If count is 0, go to DONE.
    - Otherwise go to HIGH and load the phase timer with HIGH_CYCLES-1.
  - HIGH: pulse_out=1. On entry, `edges_sent` increments. When the timer is 0, decrement `remaining`, go to LOW, and load LOW_CYCLES-1.
  - LOW: pulse_out=0. When the timer is 0:
    - If `remaining` is 0, go to DONE.
    - Otherwise go to HIGH and reload the timer.
  - DONE: done=1 for exactly one cycle, then IDLE. `edges_sent` holds its value until the next accept.
- Latency:
  - pulse_out rises in the cycle after acceptance.
  - A pulse period is HIGH_CYCLES+LOW_CYCLES.
  - `done` asserts LOW_CYCLES cycles after the final falling edge, i.e. in the cycle after the last low phase ends.
  - Total time from accept to `done` is N*(HIGH_CYCLES+LOW_CYCLES)+1 cycles; for N=0 it is 1 cycle.
- At least one low cycle always separates two high phases, so no edge merges with the next.
- `cmd_valid` while busy is ignored. The caller holds it until `cmd_ready`.
- The command and `cmd_count` need not remain stable after acceptance.
- Maximum count 2^CNT_W-1. `edges_sent` never wraps within one command.
- Phase timer width is clog2(max(HIGH_CYCLES,LOW_CYCLES)+1). A count of 1 phase-cycle means the timer loads 0.
- Elaboration error if HIGH_CYCLES<1 or LOW_CYCLES<1.

Decomposition:
- Package `pulse_train_pkg`:
  - state enum typedef: IDLE, HIGH, LOW, DONE.
  - parameter-check helper.
  - timer-width function.
- Sub-module `pulse_phase_timer`:
  - loadable down-counter with `load`, `load_val` and a `zero` flag.
  - asynchronous active-high reset to 0.
  - reused for the HIGH and LOW phases.

Test Plan:
- Defaults, accept count=4 → pulse_out 1,0,1,0,1,0,1,0 in consecutive cycles; edges_sent steps 1..4; done on cycle 9 after accept; cmd_ready=0 until done.
- HIGH_CYCLES=3, LOW_CYCLES=2, count=2 → high 3 / low 2 / high 3 / low 2; done at cycle 11; a posedge counter in a separate always block reads exactly 2.
- count=0 → pulse_out stays 0, done one cycle after accept, edges_sent=0, back to IDLE.
- Assert rst mid-high of count=5 → pulse_out=0 within the same timestep, no done; after release cmd_ready=1, and a new count=1 yields exactly 1 edge.
- cmd_valid held high with a changing cmd_count during a train of 3 → exactly 3 edges; the next command is accepted only in the cycle after done.
- count=255 (CNT_W=8) → edges_sent reaches 255 with no wrap, done once.
